// File: rtl/life_pkg.sv
// life_pkg: shared FSM states, phase-length helpers and the Life rule for the life engine.
package life_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, COMPUTE, ALIGN} state_t;
  function automatic int prime_len(input int x);
    return x + 2;
  endfunction
  function automatic int align_len(input int x, input int y);
    return x * y - x - 2;
  endfunction
  localparam int PRIME_LEN = prime_len(8);
  localparam int ALIGN_LEN = align_len(8, 8);
  function automatic logic life_rule(input logic [7:0] nb, input logic c);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b0, nb[i]};
    return (n == 4'd3) | ((n == 4'd2) & c);
  endfunction
endpackage

// File: rtl/life_engine_if.sv
// life_engine_if: key inputs, ring data and engine status bundle between the engine and its environment.
interface life_engine_if #(parameter int N = 64, parameter int GEN_W = 16);
  logic             key_step;
  logic             key_run;
  logic [N-1:0]     data;
  logic             nxt_bit;
  logic             pipe_out;
  logic             busy;
  logic             running;
  logic [GEN_W-1:0] gen_count;
  modport master (input key_step, key_run, data, output nxt_bit, pipe_out, busy, running, gen_count);
  modport slave (output key_step, key_run, data, input nxt_bit, pipe_out, busy, running, gen_count);
endinterface

// File: rtl/life_step_timer.sv
// life_step_timer: shift prescaler plus release detectors for the step and run keys.
module life_step_timer #(
  parameter int STEP_DIV = 4,
  parameter int DIV_W    = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_step,
  input  logic i_key_run,
  input  logic i_clr,
  output logic o_tick,
  output logic o_step_req,
  output logic o_run_toggle
);
  logic [DIV_W-1:0] r_div;
  logic             r_step_d;
  logic             r_run_d;
  assign o_tick       = r_div == DIV_W'(STEP_DIV - 1);
  assign o_step_req   = r_step_d & ~i_key_step;
  assign o_run_toggle = r_run_d & ~i_key_run;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div    <= '0;
      r_step_d <= 1'b0;
      r_run_d  <= 1'b0;
    end else begin
      r_div    <= (i_clr | o_tick) ? '0 : r_div + 1'b1;
      r_step_d <= i_key_step;
      r_run_d  <= i_key_run;
    end
  end
endmodule

// File: rtl/life_engine.sv
// life_engine: paces the life_data ring and computes each cell's next generation on pipe_out.
// Define LIFE_GEN_COUNT_EN to build the completed-generation counter; otherwise gen_count reads 0.
module life_engine
  import life_pkg::*;
#(
  parameter int X        = 8,
  parameter int Y        = 8,
  parameter int LOG2X    = 3,
  parameter int LOG2Y    = 3,
  parameter int STEP_DIV = 4,
  parameter int DIV_W    = 24,
  parameter int GEN_W    = 16
) (
  input logic          clk,
  input logic          reset,
  life_engine_if.master bus
);
  localparam int N       = X * Y;
  localparam int P       = (Y - 1) * X - 3;
  localparam int Q       = P + 1;
  localparam int CNT_W   = $clog2(N);
  localparam int PRIME_N = prime_len(X);
  localparam int ALIGN_N = align_len(X, Y);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [LOG2X-1:0] r_col, w_col_nxt;
  logic [LOG2Y-1:0] r_row, w_row_nxt;
  logic [X:0]       r_hist;
  logic             r_pipe, r_running;
  logic             w_tick, w_step_req, w_run_toggle, w_shift, w_last, w_run_nxt, w_col_end;
  logic             w_top, w_bot, w_lft, w_rgt;
  logic [7:0]       w_nb;

  life_step_timer #(.STEP_DIV(STEP_DIV), .DIV_W(DIV_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_key_step   (bus.key_step),
    .i_key_run    (bus.key_run),
    .i_clr        (r_state == IDLE),
    .o_tick       (w_tick),
    .o_step_req   (w_step_req),
    .o_run_toggle (w_run_toggle)
  );

  assign w_shift   = w_tick & (r_state != IDLE);
  assign w_run_nxt = r_running ^ w_run_toggle;
  assign w_col_end = r_col == LOG2X'(X - 1);
  assign w_last    = r_state == PRIME ? r_cnt == CNT_W'(PRIME_N - 1) :
                     r_state == ALIGN ? r_cnt == CNT_W'(ALIGN_N - 1) :
                     w_col_end && r_row == LOG2Y'(Y - 1);

  // Off-grid neighbours read as dead; diagonals carry both row and column masks.
  assign w_top = r_row != '0;
  assign w_bot = r_row != LOG2Y'(Y - 1);
  assign w_lft = r_col != '0;
  assign w_rgt = !w_col_end;
  assign w_nb  = {bus.data[Q+X-1] & w_bot & w_lft, bus.data[Q+X] & w_bot,
                  bus.data[Q+X+1] & w_bot & w_rgt, bus.data[Q+1] & w_rgt,
                  r_hist[0] & w_lft, r_hist[X] & w_top & w_lft,
                  r_hist[X-1] & w_top, r_hist[X-2] & w_top & w_rgt};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    if (r_state == IDLE) begin
      w_state_nxt = (w_step_req | w_run_nxt) ? PRIME : IDLE;
    end else if (w_shift) begin
      w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
      if (r_state == COMPUTE) begin
        w_col_nxt = w_col_end ? '0 : r_col + 1'b1;
        w_row_nxt = w_last ? '0 : w_col_end ? r_row + 1'b1 : r_row;
      end
      if (w_last)
        w_state_nxt = r_state == PRIME ? COMPUTE : r_state == COMPUTE ? ALIGN : w_run_nxt ? PRIME : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_hist    <= '0;
      r_pipe    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_pipe    <= r_state == COMPUTE ? life_rule(w_nb, bus.data[Q]) : bus.data[Q];
      r_running <= w_run_nxt;
      if (w_shift) r_hist <= {r_hist[X-1:0], bus.data[Q]};
    end
  end

  assign bus.nxt_bit  = w_shift;
  assign bus.pipe_out = r_pipe;
  assign bus.busy     = r_state != IDLE;
  assign bus.running  = r_running;

`ifdef LIFE_GEN_COUNT_EN
  logic [GEN_W-1:0] r_gen;
  always_ff @(posedge clk) begin
    if (!reset) r_gen <= '0;
    else if (w_shift && r_state == ALIGN && w_last) r_gen <= r_gen + 1'b1;
  end
  assign bus.gen_count = r_gen;
`else
  assign bus.gen_count = '0;
`endif
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: randomized self-checking bench with a ring model and a grid-level Life reference.
module tb_life_engine;
  localparam int N = 64;
  localparam int P = 53;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_en = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] ring = '0;
  int n_cmp = 0;
  int n_err = 0;
  int exp_gen = 0;

  life_engine_if #(.N(N), .GEN_W(16)) bus ();
  life_engine dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  assign bus.data = ring;

  function automatic logic [N-1:0] shift_ring(input logic [N-1:0] r, input logic b);
    logic [N-1:0] t;
    t = {r[0], r[N-1:1]};
    t[P] = b;
    return t;
  endfunction

  // Stand-in for life_data: rotates toward index 0 and writes pipe_out at P.
  always @(posedge clk) begin
    if (load_en) ring <= load_val;
    else if (bus.nxt_bit) ring <= shift_ring(ring, bus.pipe_out);
  end

  function automatic logic [N-1:0] life_ref(input logic [N-1:0] g);
    logic [N-1:0] o;
    int n;
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              n += int'(g[(r + dr) * 8 + c + dc]);
        o[r * 8 + c] = (n == 3) || (n == 2 && g[r * 8 + c]);
      end
    return o;
  endfunction

  function automatic logic [N-1:0] cells(input int a, input int b, input int c, input int d);
    logic [N-1:0] g;
    g = '0;
    if (a >= 0) g[a] = 1'b1;
    if (b >= 0) g[b] = 1'b1;
    if (c >= 0) g[c] = 1'b1;
    if (d >= 0) g[d] = 1'b1;
    return g;
  endfunction

  function automatic logic [15:0] gc_exp();
`ifdef LIFE_GEN_COUNT_EN
    return 16'(exp_gen);
`else
    return 16'd0;
`endif
  endfunction

  task automatic load_grid(input logic [N-1:0] g);
    @(negedge clk);
    load_en = 1'b1;
    load_val = g;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Releases the requested keys, then watches shifts until the engine goes idle.
  task automatic gen_loop(input bit do_step, input bit do_run, input int stop_at, input int step_at,
                          output int pulses, output int bad_gap, output int first_at,
                          output int busy_cyc, output bit timeout);
    int last;
    pulses = 0; bad_gap = 0; first_at = -1; busy_cyc = 0; last = 0;
    @(negedge clk);
    bus.key_step = do_step;
    bus.key_run = do_run;
    @(negedge clk);
    bus.key_step = 1'b0;
    bus.key_run = 1'b0;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      @(negedge clk);
      bus.key_step = 1'b0;
      bus.key_run = 1'b0;
      if (bus.nxt_bit) begin
        if (first_at < 0) first_at = cyc;
        else if (cyc - last != 4) bad_gap++;
        last = cyc;
        pulses++;
        if (pulses == stop_at) bus.key_run = 1'b1;
        if (pulses == step_at) bus.key_step = 1'b1;
      end
      if (!bus.busy) break;
      busy_cyc++;
    end
    timeout = bus.busy;
    exp_gen += pulses / 128;
  endtask

  task automatic test_reset();
    load_grid('0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.nxt_bit, bus.pipe_out, bus.busy, bus.running} !== 4'b0 || bus.gen_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got nxt/pipe/busy/run=%b gen=%0d want 0000 gen=0",
               {bus.nxt_bit, bus.pipe_out, bus.busy, bus.running}, bus.gen_count);
    end
    reset = 1'b1;
    exp_gen = 0;
  endtask

  task automatic test_passthrough();
    load_grid(cells(54, -1, -1, -1));
    @(negedge clk);
    n_cmp++;
    if (bus.pipe_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_passthrough: pipe_out=%b busy=%b want 1 0", bus.pipe_out, bus.busy);
    end
  endtask

  task automatic test_blinker();
    logic [N-1:0] g0;
    int p, bg, fa, bc;
    bit to;
    g0 = cells(26, 27, 28, -1);
    load_grid(g0);
    gen_loop(1, 0, -1, -1, p, bg, fa, bc, to);
    n_cmp++;
    if (p !== 128 || to) begin n_err++; $display("FAIL blinker_pulses: got %0d (timeout=%0d) want 128", p, to); end
    n_cmp++;
    if (bg !== 0 || fa !== 4) begin n_err++; $display("FAIL blinker_spacing: bad_gaps=%0d first_at=%0d want 0 and 4", bg, fa); end
    n_cmp++;
    if (bc !== 512) begin n_err++; $display("FAIL blinker_busy_len: got %0d want 512", bc); end
    n_cmp++;
    if (ring !== cells(19, 27, 35, -1)) begin n_err++; $display("FAIL blinker_gen1: got %h want %h", ring, cells(19, 27, 35, -1)); end
    gen_loop(1, 0, -1, -1, p, bg, fa, bc, to);
    n_cmp++;
    if (ring !== g0 || p !== 128) begin n_err++; $display("FAIL blinker_gen2: got %h pulses %0d want %h 128", ring, p, g0); end
    n_cmp++;
    if (bus.gen_count !== gc_exp()) begin n_err++; $display("FAIL gen_count_blinker: got %0d want %0d", bus.gen_count, gc_exp()); end
  endtask

  task automatic test_patterns();
    logic [N-1:0] g, e;
    int p, bg, fa, bc;
    bit to;
    for (int i = 0; i < 3; i++) begin
      g = i == 0 ? cells(0, 1, 8, 9) : i == 1 ? cells(0, 1, 8, -1) : cells(6, 7, 8, -1);
      e = i == 0 ? cells(0, 1, 8, 9) : i == 1 ? cells(0, 1, 8, 9) : '0;
      load_grid(g);
      gen_loop(1, 0, -1, -1, p, bg, fa, bc, to);
      n_cmp++;
      if (ring !== e || ring !== life_ref(g) || p !== 128) begin
        n_err++;
        $display("FAIL pattern_%0d: got %h pulses %0d want %h 128", i, ring, p, e);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    int p, bg, fa, bc;
    bit to;
    for (int i = 0; i < 8; i++) begin
      g = {$urandom, $urandom};
      if (i[0]) g = g & {$urandom, $urandom};
      load_grid(g);
      gen_loop(1, 0, -1, -1, p, bg, fa, bc, to);
      n_cmp++;
      if (ring !== life_ref(g) || p !== 128 || bg !== 0 || to) begin
        n_err++;
        $display("FAIL random_%0d: from %h got %h want %h pulses %0d gaps %0d", i, g, ring, life_ref(g), p, bg);
      end
    end
    n_cmp++;
    if (bus.gen_count !== gc_exp()) begin n_err++; $display("FAIL gen_count_random: got %0d want %0d", bus.gen_count, gc_exp()); end
  endtask

  task automatic test_busy_ignore();
    logic [N-1:0] g;
    int p, bg, fa, bc;
    bit to;
    g = {$urandom, $urandom};
    load_grid(g);
    gen_loop(1, 0, -1, 40, p, bg, fa, bc, to);
    repeat (12) @(negedge clk);
    n_cmp++;
    if (p !== 128 || bus.busy !== 1'b0 || ring !== life_ref(g)) begin
      n_err++;
      $display("FAIL step_while_busy: pulses %0d busy %b got %h want 128 0 %h", p, bus.busy, ring, life_ref(g));
    end
  endtask

  task automatic test_run_mode();
    logic [N-1:0] g;
    int p, bg, fa, bc;
    bit to;
    g = {$urandom, $urandom};
    load_grid(g);
    gen_loop(0, 1, 296, -1, p, bg, fa, bc, to);
    n_cmp++;
    if (p !== 384 || bc !== 1536 || bg !== 0 || to) begin
      n_err++;
      $display("FAIL run_back_to_back: pulses %0d busy %0d gaps %0d want 384 1536 0", p, bc, bg);
    end
    n_cmp++;
    if (bus.running !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL run_stop: running %b busy %b want 0 0", bus.running, bus.busy); end
    n_cmp++;
    if (ring !== life_ref(life_ref(life_ref(g)))) begin n_err++; $display("FAIL run_result: got %h want %h", ring, life_ref(life_ref(life_ref(g)))); end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] g;
    int p, bg, fa, bc;
    bit to;
    g = {$urandom, $urandom};
    load_grid(g);
    gen_loop(1, 1, 30, -1, p, bg, fa, bc, to);
    n_cmp++;
    if (p !== 128 || bus.running !== 1'b0 || ring !== life_ref(g)) begin
      n_err++;
      $display("FAIL step_and_run: pulses %0d running %b got %h want 128 0 %h", p, bus.running, ring, life_ref(g));
    end
    n_cmp++;
    if (bus.gen_count !== gc_exp()) begin n_err++; $display("FAIL gen_count_run: got %0d want %0d", bus.gen_count, gc_exp()); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g;
    int p, bg, fa, bc, seen;
    bit to;
    g = {$urandom, $urandom};
    load_grid(g);
    @(negedge clk); bus.key_step = 1'b1;
    @(negedge clk); bus.key_step = 1'b0;
    seen = 0;
    for (int c = 0; c < 1000 && seen < 30; c++) begin
      @(negedge clk);
      if (bus.nxt_bit) seen++;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_gen = 0;
    n_cmp++;
    if (seen !== 30 || {bus.nxt_bit, bus.pipe_out, bus.busy, bus.running} !== 4'b0 || bus.gen_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mid: seen %0d outs %b gen %0d want 30 0000 0", seen,
               {bus.nxt_bit, bus.pipe_out, bus.busy, bus.running}, bus.gen_count);
    end
    load_grid(g);
    gen_loop(1, 0, -1, -1, p, bg, fa, bc, to);
    n_cmp++;
    if (p !== 128 || ring !== life_ref(g) || bus.gen_count !== gc_exp()) begin
      n_err++;
      $display("FAIL after_reset_gen: pulses %0d got %h gen %0d want 128 %h %0d", p, ring, bus.gen_count, life_ref(g), gc_exp());
    end
  endtask

  initial begin
    bus.key_step = 1'b0;
    bus.key_run = 1'b0;
    test_reset();
    test_passthrough();
    test_blinker();
    test_patterns();
    test_random();
    test_busy_ignore();
    test_run_mode();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/life_engine.md
# life_engine

Generation engine for the Game of Life ring. It paces the shifts of the `life_data` ring register through `nxt_bit` and computes each cell's next state on `pipe_out` from the ring contents plus a private history of overwritten cells. It sits directly upstream of `life_data`, driving its `nxt_bit` and `pipe_out` inputs and reading its `data` output. User keys request a single generation or toggle free-running mode.

## Interface
- `X`, default 8: grid width; must be ≥4.
- `Y`, default 8: grid height; must be ≥3.
- `LOG2X`, default 3: width of the column counter.
- `LOG2Y`, default 3: width of the row counter.
- `STEP_DIV`, default 4: clocks per ring shift; must be ≥2.
- `DIV_W`, default 24: prescaler width.
- `GEN_W`, default 16: generation counter width.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low.
- `key_step`  in  1  level key; a release (1→0) requests one generation.
- `key_run`  in  1  level key; a release toggles free-running mode.
- `data`  in  X*Y  ring contents from `life_data`.
- `nxt_bit`  out  1  single-cycle shift strobe to the ring.
- `pipe_out`  out  1  registered bit the ring writes at index P=(Y-1)*X-3.
- `busy`  out  1  high while a generation is in progress.
- `running`  out  1  free-running mode flag.
- `gen_count`  out  GEN_W  completed generations.

## Operation
- N=X*Y. Q=P+1 is the centre tap. Each shift drops the old `data[Q]`; the engine captures it into history register H, length X+1. H shifts on `nxt_bit` with H[0]←data[Q], so H[j] holds the cell at Q-1-j.
- States: IDLE, PRIME (X+2 shifts), COMPUTE (N shifts), ALIGN (N-X-2 shifts). One generation is 2N shifts, so the grid ends unrotated.
- IDLE→PRIME on a `key_step` release, or when `running`=1. Mode changes at the last shift of each phase. ALIGN→IDLE, or →PRIME when `running`=1.
- In PRIME, ALIGN and IDLE, `pipe_out` is pass-through: `pipe_out`=data[Q], so ring content is unchanged.
- In COMPUTE, cell counter k runs 0..N-1 with col=k%X and row=k/X, held as separate X/Y counters.
- Neighbours in COMPUTE:
  - data[Q+X-1], data[Q+X], data[Q+X+1] are row+1.
  - data[Q+1] is col+1.
  - H[0] is col-1.
  - H[X], H[X-1], H[X-2] are row-1.
- Dead boundary: neighbours off-grid are masked to 0. The row+1 taps are masked when row=Y-1; the row-1 taps when row=0; the col+1 taps when col=X-1; the col-1 taps when col=0. The grid never wraps as a torus.
- Rule: 3 neighbours→1; 2 neighbours→centre data[Q]; otherwise→0.
- `running` toggles on a `key_run` release. Turning it off mid-generation completes that generation.
- A `key_step` release while busy is ignored.
- Key edges use registered delay flops: release means delayed=1 and current=0.

## Timing
- Reset (`reset`=0 at an edge) → next cycle: state IDLE; all counters and H zero; `nxt_bit`, `pipe_out`, `busy`, `running` and `gen_count` all 0. This applies mid-generation too; the ring is then left partially updated.
- Key release sampled at edge t → state PRIME and prescaler cleared at t+1. The first `nxt_bit` is at t+STEP_DIV, and pulses follow every STEP_DIV cycles. `nxt_bit` is never high in consecutive cycles.
- `pipe_out` is registered every cycle from the current `data`, H, state and counters. It is therefore valid in the `nxt_bit` cycle.
- State, counters and H update on the `nxt_bit` cycle.
- `busy` is high from t+1 through the cycle of the final ALIGN `nxt_bit`.
- A single generation takes 2N×STEP_DIV cycles.
- Simultaneous `key_step` and `key_run` releases in IDLE: run wins, and the generation starts once.

## Configuration
- `LIFE_GEN_COUNT_EN` defined: `gen_count` increments, wrapping, on the final ALIGN `nxt_bit`.
- `LIFE_GEN_COUNT_EN` undefined: `gen_count` is tied to 0 and no counter is built. The port stays for a stable interface.

## Structure
- Shared package `life_pkg` holds:
  - the state enum (IDLE, PRIME, COMPUTE, ALIGN);
  - phase-length constants PRIME_LEN=X+2 and ALIGN_LEN=N-X-2;
  - the Life rule function.
- One sub-module, `life_step_timer`: the prescaler plus both key edge detectors, producing `tick`, `step_req` and `run_toggle`.

## Test plan
All scenarios use the default parameters with `life_engine` driving a `life_data` instance; cell index = row*8+col.
1. Blinker: cells {26,27,28}, `key_step` release → exactly 128 `nxt_bit` pulses, 4 cycles apart; data={19,27,35}. A second step returns {26,27,28}.
2. Block still-life: {0,1,8,9} → unchanged after one generation. An L-shape {0,1,8} → {0,1,8,9}.
3. Edge mask: {6,7,8} → all zero after one generation; no linear or torus wrap.
4. Run mode: `key_run` release → generations back-to-back with no IDLE cycle. Release again mid-COMPUTE → the generation completes, then IDLE; `busy`=0 and `running`=0.
5. Reset mid-COMPUTE: `reset`=0 for one edge → next cycle all outputs 0 and state IDLE; a subsequent step produces a full 128 pulses.
6. With `LIFE_GEN_COUNT_EN`: three steps → `gen_count`=3. Without the macro: `gen_count`=0 throughout.
